// File: rtl/extbus_master_if.sv
// Command, response and external-bus signals of extbus_master.
// master: the sequencer's view. slave: the command source and bus pad side.
interface extbus_master_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
);
  // Command channel (valid/ready)
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CNT_W-1:0]  cmd_count;

  // Response and status
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  // External 6502-style bus
  logic              bus_cs_n;
  logic              bus_rd_n;
  logic              bus_wr_n;
  logic [ADDR_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_d_out;
  logic              bus_d_oe;
  logic [DATA_W-1:0] bus_d_in;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_count, bus_d_in,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output bus_cs_n, bus_rd_n, bus_wr_n, bus_a, bus_d_out, bus_d_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_count, bus_d_in,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  bus_cs_n, bus_rd_n, bus_wr_n, bus_a, bus_d_out, bus_d_oe
  );
endinterface

// File: rtl/extbus_master.sv
// Host-side sequencer for the 6502-style external bus of the video block.
// Turns read/write commands into bus cycles with programmable setup, strobe
// and hold lengths. All outputs are registered.
// Optional feature: define EXTBUS_MASTER_BURST_EN to honour cmd_count and
// repeat the cycle to one address (GAP state between beats). Without it every
// command is a single beat.
module extbus_master #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned CNT_W      = 4
) (
  input logic             clk,
  input logic             rst_n,
  extbus_master_if.master bus
);

  localparam int unsigned MaxCyc =
      (SETUP_CYC > STROBE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                               : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int unsigned PhW = $clog2(MaxCyc) + 1;

  // Phase counters load "length - 1" and count down to zero.
  localparam logic [PhW-1:0] SetupLast  = PhW'(SETUP_CYC - 1);
  localparam logic [PhW-1:0] StrobeLast = PhW'(STROBE_CYC - 1);
  localparam logic [PhW-1:0] HoldLast   = PhW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
`ifdef EXTBUS_MASTER_BURST_EN
    , StGap
`endif
  } state_e;

  state_e            state_q;
  logic [PhW-1:0]    phase_q;
  logic              write_q;
  logic              ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              cs_n_q;
  logic              rd_n_q;
  logic              wr_n_q;
  // bus_a / bus_d_out registers double as the latched command address and data.
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] dout_q;
  logic              oe_q;

`ifdef EXTBUS_MASTER_BURST_EN
  logic [CNT_W-1:0]  beats_q;  // beats still to run after the current one
`else
  logic unused_count;
  assign unused_count = ^bus.cmd_count;
`endif

  // Bus-cycle FSM; every output is produced as a register alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      write_q     <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      a_q         <= '0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
`ifdef EXTBUS_MASTER_BURST_EN
      beats_q     <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid && ready_q) begin
            state_q <= StSetup;
            phase_q <= SetupLast;
            write_q <= bus.cmd_write;
            a_q     <= bus.cmd_addr;
            dout_q  <= bus.cmd_wdata;
            oe_q    <= bus.cmd_write;
            cs_n_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef EXTBUS_MASTER_BURST_EN
            beats_q <= bus.cmd_count;
`endif
          end
        end

        StSetup: begin
          if (phase_q == '0) begin
            state_q <= StStrobe;
            phase_q <= StrobeLast;
            rd_n_q  <= write_q;
            wr_n_q  <= ~write_q;
          end else begin
            phase_q <= phase_q - PhW'(1);
          end
        end

        StStrobe: begin
          if (phase_q == '0) begin
            state_q <= StHold;
            phase_q <= HoldLast;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            // Pad data is sampled on the edge that closes the read strobe.
            if (!write_q) begin
              rsp_data_q  <= bus.bus_d_in;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            phase_q <= phase_q - PhW'(1);
          end
        end

        StHold: begin
          if (phase_q == '0) begin
            cs_n_q <= 1'b1;
            oe_q   <= 1'b0;
`ifdef EXTBUS_MASTER_BURST_EN
            if (beats_q != '0) begin
              state_q <= StGap;
              beats_q <= beats_q - CNT_W'(1);
            end else begin
              state_q <= StIdle;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
`else
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`endif
          end else begin
            phase_q <= phase_q - PhW'(1);
          end
        end

`ifdef EXTBUS_MASTER_BURST_EN
        StGap: begin
          state_q <= StSetup;
          phase_q <= SetupLast;
          cs_n_q  <= 1'b0;
          oe_q    <= write_q;
        end
`endif

        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.bus_cs_n  = cs_n_q;
  assign bus.bus_rd_n  = rd_n_q;
  assign bus.bus_wr_n  = wr_n_q;
  assign bus.bus_a     = a_q;
  assign bus.bus_d_out = dout_q;
  assign bus.bus_d_oe  = oe_q;

endmodule

// File: tb/tb_extbus_master.sv
// Directed self-checking bench for extbus_master with default timing
// (setup 2, strobe 3, hold 1). Cycle k = k-th cycle after the accept edge.
module tb_extbus_master;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  // {cs_n, rd_n, wr_n, oe, cmd_ready, rsp_valid, busy}
  localparam logic [6:0] CtlIdle = 7'b111_0100;

  logic clk;
  logic rst_n;

  extbus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

  extbus_master #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SETUP_CYC (2),
    .STROBE_CYC(3),
    .HOLD_CYC  (1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  logic [6:0] ctl;
  assign ctl = {bus_if.bus_cs_n, bus_if.bus_rd_n, bus_if.bus_wr_n, bus_if.bus_d_oe,
                bus_if.cmd_ready, bus_if.rsp_valid, bus_if.busy};

  int n_cmp;
  int n_fail;

  logic [7:0] din_pat [0:40];
  logic [6:0] obs_ctl [0:40];
  logic [4:0] obs_a   [0:40];
  logic [7:0] obs_d   [0:40];
  logic [7:0] obs_rsp [0:40];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control vector for one single-beat command, cycle k after accept.
  function automatic logic [6:0] exp_single(input int k, input logic w);
    logic act, stb;
    act = (k >= 1) && (k <= 6);
    stb = (k >= 3) && (k <= 5);
    return {~act, ~(stb & ~w), ~(stb & w), act & w, ~act, (k == 6) & ~w, act};
  endfunction

  // Offer one command, then record ncyc cycles sampled at the falling edge.
  task automatic run_cmd(input logic w, input logic [4:0] a, input logic [7:0] d,
                         input logic [3:0] cnt, input int ncyc);
    bus_if.cmd_write = w;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
    bus_if.cmd_count = cnt;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      bus_if.bus_d_in = din_pat[k];
      @(negedge clk);
      obs_ctl[k] = ctl;
      obs_a[k]   = bus_if.bus_a;
      obs_d[k]   = bus_if.bus_d_out;
      obs_rsp[k] = bus_if.rsp_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_addr  = 5'h1F;
    bus_if.cmd_wdata = 8'hFF;
    bus_if.cmd_count = 4'h0;
    bus_if.bus_d_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
    rst_n            = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctl !== CtlIdle) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b", ctl, CtlIdle);
    end
    n_cmp++;
    if ({bus_if.bus_a, bus_if.bus_d_out, bus_if.rsp_data} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_regs: a=%h d=%h rsp=%h want all 0",
               bus_if.bus_a, bus_if.bus_d_out, bus_if.rsp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    for (int k = 0; k <= 40; k++) din_pat[k] = 8'h00;
    run_cmd(1'b1, 5'h05, 8'h01, 4'h0, 8);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (obs_ctl[k] !== exp_single(k, 1'b1)) begin
        n_fail++;
        $display("FAIL write_ctl cyc %0d: got %b want %b", k, obs_ctl[k], exp_single(k, 1'b1));
      end
      n_cmp++;
      if ({obs_a[k], obs_d[k]} !== {5'h05, 8'h01}) begin
        n_fail++;
        $display("FAIL write_addr_data cyc %0d: got a=%h d=%h want a=05 d=01",
                 k, obs_a[k], obs_d[k]);
      end
    end
  endtask

  task automatic test_read();
    for (int k = 0; k <= 40; k++) din_pat[k] = (k >= 3 && k <= 5) ? 8'hA1 : 8'h3C;
    run_cmd(1'b0, 5'h04, 8'hFF, 4'h0, 8);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (obs_ctl[k] !== exp_single(k, 1'b0)) begin
        n_fail++;
        $display("FAIL read_ctl cyc %0d: got %b want %b", k, obs_ctl[k], exp_single(k, 1'b0));
      end
      n_cmp++;
      if (obs_a[k] !== 5'h04) begin
        n_fail++;
        $display("FAIL read_addr cyc %0d: got %h want 04", k, obs_a[k]);
      end
    end
    n_cmp++;
    if (obs_rsp[6] !== 8'hA1) begin
      n_fail++;
      $display("FAIL read_data: got %h want a1", obs_rsp[6]);
    end
  endtask

`ifdef EXTBUS_MASTER_BURST_EN
  task automatic test_burst();
    int p, b, busy_cnt, pulses;
    logic act, stb;
    logic [6:0] exp;
    logic [7:0] exp_d;
    for (int k = 0; k <= 40; k++) begin
      p = (k - 1) % 7 + 1;
      b = (k - 1) / 7;
      din_pat[k] = (k >= 1 && k <= 27 && p >= 3 && p <= 5) ? 8'(8'hA1 + b) : 8'h00;
    end
    run_cmd(1'b0, 5'h04, 8'h00, 4'd3, 30);
    busy_cnt = 0;
    pulses   = 0;
    for (int k = 1; k <= 30; k++) begin
      p     = (k - 1) % 7 + 1;
      b     = (k - 1) / 7;
      act   = (k <= 27) && (p <= 6);
      stb   = act && (p >= 3) && (p <= 5);
      exp   = {~act, ~stb, 1'b1, 1'b0, k > 27, act && (p == 6), k <= 27};
      exp_d = 8'(8'hA1 + b);
      if (obs_ctl[k][0]) busy_cnt++;
      if (obs_ctl[k][1]) pulses++;
      n_cmp++;
      if (obs_ctl[k] !== exp) begin
        n_fail++;
        $display("FAIL burst_ctl cyc %0d: got %b want %b", k, obs_ctl[k], exp);
      end
      n_cmp++;
      if (obs_a[k] !== 5'h04) begin
        n_fail++;
        $display("FAIL burst_addr cyc %0d: got %h want 04", k, obs_a[k]);
      end
      if (act && p == 6) begin
        n_cmp++;
        if (obs_rsp[k] !== exp_d) begin
          n_fail++;
          $display("FAIL burst_data beat %0d: got %h want %h", b, obs_rsp[k], exp_d);
        end
      end
    end
    n_cmp++;
    if (busy_cnt != 27) begin
      n_fail++;
      $display("FAIL burst_busy_len: got %0d want 27", busy_cnt);
    end
    n_cmp++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL burst_rsp_count: got %0d want 4", pulses);
    end
  endtask
`else
  task automatic test_no_burst();
    int pulses;
    for (int k = 0; k <= 40; k++) din_pat[k] = (k >= 3 && k <= 5) ? 8'hA7 : 8'h00;
    run_cmd(1'b0, 5'h04, 8'h00, 4'd3, 16);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      if (obs_ctl[k][1]) pulses++;
      n_cmp++;
      if (obs_ctl[k] !== exp_single(k, 1'b0)) begin
        n_fail++;
        $display("FAIL single_ctl cyc %0d: got %b want %b", k, obs_ctl[k], exp_single(k, 1'b0));
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL single_rsp_count: got %0d want 1", pulses);
    end
    n_cmp++;
    if (obs_rsp[6] !== 8'hA7) begin
      n_fail++;
      $display("FAIL single_data: got %h want a7", obs_rsp[6]);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int kk;
    logic [4:0] ea;
    logic [7:0] ed;
    bus_if.bus_d_in  = 8'h00;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_addr  = 5'h00;
    bus_if.cmd_wdata = 8'h00;
    bus_if.cmd_count = 4'h0;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    // Second command offered while the first is still running.
    bus_if.cmd_addr  = 5'h01;
    bus_if.cmd_wdata = 8'h40;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      kk = (k <= 7) ? k : k - 7;
      ea = (k <= 7) ? 5'h00 : 5'h01;
      ed = (k <= 7) ? 8'h00 : 8'h40;
      n_cmp++;
      if (ctl !== exp_single(kk, 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_ctl cyc %0d: got %b want %b", k, ctl, exp_single(kk, 1'b1));
      end
      n_cmp++;
      if ({bus_if.bus_a, bus_if.bus_d_out} !== {ea, ed}) begin
        n_fail++;
        $display("FAIL b2b_addr_data cyc %0d: got a=%h d=%h want a=%h d=%h",
                 k, bus_if.bus_a, bus_if.bus_d_out, ea, ed);
      end
      @(posedge clk); #1;
      if (k == 7) bus_if.cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bus_if.bus_d_in  = 8'h00;
    bus_if.cmd_write = 1'b1;
    bus_if.cmd_addr  = 5'h1F;
    bus_if.cmd_wdata = 8'h5A;
    bus_if.cmd_count = 4'hF;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (ctl !== exp_single(4, 1'b1)) begin
      n_fail++;
      $display("FAIL rstmid_pre cyc 4: got %b want %b", ctl, exp_single(4, 1'b1));
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctl !== CtlIdle) begin
      n_fail++;
      $display("FAIL rstmid_ctl: got %b want %b", ctl, CtlIdle);
    end
    n_cmp++;
    if ({bus_if.bus_a, bus_if.bus_d_out} !== 13'h0) begin
      n_fail++;
      $display("FAIL rstmid_regs: a=%h d=%h want 0", bus_if.bus_a, bus_if.bus_d_out);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl !== CtlIdle) begin
        n_fail++;
        $display("FAIL rstmid_dropped %0d: got %b want %b", i, ctl, CtlIdle);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k <= 40; k++) din_pat[k] = (k >= 3 && k <= 5) ? 8'hA2 : 8'h00;
    run_cmd(1'b0, 5'h04, 8'h00, 4'h0, 8);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (obs_ctl[k] !== exp_single(k, 1'b0)) begin
        n_fail++;
        $display("FAIL rstmid_read_ctl cyc %0d: got %b want %b",
                 k, obs_ctl[k], exp_single(k, 1'b0));
      end
    end
    n_cmp++;
    if (obs_rsp[6] !== 8'hA2) begin
      n_fail++;
      $display("FAIL rstmid_read_data: got %h want a2", obs_rsp[6]);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_write();
    test_read();
`ifdef EXTBUS_MASTER_BURST_EN
    test_burst();
`else
    test_no_burst();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/extbus_master.md
Name: extbus_master

Overview:
Synthesizable, parametrised host-side sequencer for the 6502-style external bus (cs_n, rd_n, wr_n, address, 8-bit data) that the video block exposes. It takes read/write commands over a valid/ready interface and produces bus cycles with programmable setup, strobe and hold lengths. In burst mode it repeats a cycle to one address, which matches the data-port auto-increment usage. It replaces hand-timed bus stimulus and is the bus driver for on-chip self-test and a future host bridge.

Parameters:
ADDR_W, 5, bus address width
DATA_W, 8, bus data width
SETUP_CYC, 2, cycles with cs_n low and address valid before the strobe (>=1)
STROBE_CYC, 3, cycles with rd_n/wr_n low (>=1)
HOLD_CYC, 1, cycles after the strobe with cs_n, address and write data still held (>=1)
CNT_W, 4, width of the burst beat count

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  bus address
cmd_wdata  in  DATA_W  write data, repeated on every beat
cmd_count  in  CNT_W  beats minus one
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_data  out  DATA_W  read data
busy  out  1  high when not IDLE
bus_cs_n  out  1  chip select
bus_rd_n  out  1  read strobe
bus_wr_n  out  1  write strobe
bus_a  out  ADDR_W  address
bus_d_out  out  DATA_W  write data
bus_d_oe  out  1  data output enable
bus_d_in  in  DATA_W  read data from the pad

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active low and is sampled only on the rising edge of clk.
- Reset values: state IDLE, cmd_ready 1, busy 0, rsp_valid 0, rsp_data 0, bus_cs_n 1, bus_rd_n 1, bus_wr_n 1, bus_a 0, bus_d_out 0, bus_d_oe 0.
- All outputs are registered.
- State flow: IDLE -> SETUP -> STROBE -> HOLD -> GAP or IDLE; GAP -> SETUP.
- cmd_ready is high only in IDLE.
- Accept: cmd_valid and cmd_ready high at a rising edge. On that edge the block latches write, addr, wdata and count and enters SETUP. Inputs are ignored outside IDLE.
- SETUP, SETUP_CYC cycles: cs_n 0, rd_n 1, wr_n 1, bus_a = latched address, bus_d_oe = latched write flag, bus_d_out = latched data.
- STROBE, STROBE_CYC cycles: as SETUP, plus wr_n 0 for a write or rd_n 0 for a read.
- Read capture: bus_d_in is captured into rsp_data on the rising edge that ends the last STROBE cycle.
- HOLD, HOLD_CYC cycles: strobes high; cs_n, address, data and oe unchanged. For a read, rsp_valid is high in the first HOLD cycle only.
- End of HOLD:
  - beats remaining -> GAP (1 cycle: cs_n 1, strobes 1, oe 0, address held), then SETUP; the remaining-beat counter decrements.
  - otherwise -> IDLE: cs_n 1, oe 0; bus_a and bus_d_out keep their last values.
- Single-beat latency: SETUP_CYC + STROBE_CYC + HOLD_CYC cycles from the accept edge to IDLE. Back-to-back commands are separated by at least 1 cycle with cs_n high, the IDLE cycle in which the next command is accepted.
- Burst length: cmd_count = 2^CNT_W-1 gives 2^CNT_W beats. The counter never wraps past zero.
- Reset mid-cycle: at the first edge with rst_n low, every output takes its reset value. No rsp_valid is issued for the aborted beat and all remaining beats are dropped.
- rsp_valid has no backpressure; the consumer must accept it in the cycle it is asserted.
- Strobes never overlap: rd_n and wr_n are never both low. bus_d_oe is never high during a read command.

Optional Feature:
EXTBUS_MASTER_BURST_EN
- Defined: cmd_count is honoured and GAP is used between beats as described above.
- Undefined: cmd_count is ignored and every command is exactly one beat. The counter and GAP state are not built; HOLD always goes to IDLE.

Test Plan:
- Write 0x01 to address 0x05, default parameters:
  - cs_n low 6 cycles; wr_n low in cycles 3-5 only; bus_a 0x05; bus_d_out 0x01; oe high all 6 cycles.
  - cmd_ready high again in cycle 7; rsp_valid never pulses.
- Read address 0x04 with the bench driving bus_d_in = 0xA1 during strobe:
  - rd_n low 3 cycles; oe stays 0.
  - rsp_valid single pulse in cycle 6 with rsp_data 0xA1.
- Burst read (BURST_EN defined), address 0x04, cmd_count 3, bench returning 0xA1..0xA4 per beat:
  - 4 rsp_valid pulses with 0xA1, 0xA2, 0xA3, 0xA4.
  - cs_n high exactly 1 cycle between beats; busy for 27 cycles.
- Two writes offered back-to-back with cmd_valid held (0x00->addr 0, 0x40->addr 1):
  - second write accepted only in IDLE; at least 1 cs_n-high cycle between the two cycles; correct address and data on each.
- rst_n driven low during the second STROBE cycle of a write:
  - next edge gives cs_n 1, wr_n 1, oe 0, cmd_ready 1.
  - a subsequent read of 0x04 completes normally.
- BURST_EN undefined, cmd_count 3 read:
  - exactly one beat and one rsp_valid; back in IDLE after 6 cycles.
